// File: rtl/store_processing_unit.sv
// Store data path: SW is a single word write; SB/SH are read-modify-write
// against a word-only data memory. The pipeline is stalled through busy.
module store_processing_unit #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  store_req,
   input  logic [2:0]            func3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           write_data,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_busywait
);

   localparam int unsigned HALF_W = 16;
   localparam logic [2:0]  F3_SB  = 3'b000;
   localparam logic [2:0]  F3_SH  = 3'b001;
   localparam logic [2:0]  F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic                    done_nxt, error_nxt;
   logic [ADDR_WIDTH-1:0]   mem_addr_nxt;
   logic [31:0]             mem_wdata_nxt;
   logic                    cap_half, cap_half_nxt;
   logic [1:0]              cap_lane, cap_lane_nxt;
   logic [HALF_W-1:0]       cap_data, cap_data_nxt;
   logic                    legal_c;
   logic                    accept_c;
   logic [31:0]             merged_c;

   // Alignment and opcode legality of the presented request
   always_comb begin
      legal_c = 1'b0;
      case (func3)
         F3_SB:   legal_c = 1'b1;
         F3_SH:   legal_c = ~address[0];
         F3_SW:   legal_c = (address[1:0] == 2'b00);
         default: legal_c = 1'b0;
      endcase
   end

   assign accept_c  = (state == IDLE) & store_req & legal_c;
   assign mem_read  = (state == READ);
   assign mem_write = (state == WRITE);
   // Drops in the completing write cycle so the pipeline advances on that edge
   assign busy      = accept_c | (state == READ) | ((state == WRITE) & mem_busywait);

   // Little-endian lane merge of the captured store data into the read word
   always_comb begin
      merged_c = mem_rdata;
      if (cap_half) begin
         if (cap_lane[1]) merged_c[31:16] = cap_data;
         else             merged_c[15:0]  = cap_data;
      end else begin
         case (cap_lane)
            2'd0:    merged_c[7:0]   = cap_data[7:0];
            2'd1:    merged_c[15:8]  = cap_data[7:0];
            2'd2:    merged_c[23:16] = cap_data[7:0];
            default: merged_c[31:24] = cap_data[7:0];
         endcase
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt     = state;
      done_nxt      = 1'b0;
      error_nxt     = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      cap_half_nxt  = cap_half;
      cap_lane_nxt  = cap_lane;
      cap_data_nxt  = cap_data;
      case (state)
         IDLE: begin
            if (store_req) begin
               if (!legal_c) begin
                  error_nxt = 1'b1;
               end else begin
                  cap_half_nxt = (func3 == F3_SH);
                  cap_lane_nxt = address[1:0];
                  cap_data_nxt = write_data[HALF_W-1:0];
                  mem_addr_nxt = {address[ADDR_WIDTH-1:2], 2'b00};
                  if (func3 == F3_SW) begin
                     mem_wdata_nxt = write_data;
                     state_nxt     = WRITE;
                  end else begin
                     state_nxt     = READ;
                  end
               end
            end
         end
         READ: begin
            if (!mem_busywait) begin
               mem_wdata_nxt = merged_c;
               state_nxt     = WRITE;
            end
         end
         WRITE: begin
            if (!mem_busywait) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and capture registers; reset abandons any store in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         done      <= 1'b0;
         error     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cap_half  <= 1'b0;
         cap_lane  <= 2'b00;
         cap_data  <= '0;
      end else begin
         state     <= state_nxt;
         done      <= done_nxt;
         error     <= error_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         cap_half  <= cap_half_nxt;
         cap_lane  <= cap_lane_nxt;
         cap_data  <= cap_data_nxt;
      end
   end

endmodule

// File: tb/tb_store_processing_unit.sv
// Bench for store_processing_unit: word memory model with programmable
// wait states, a per-cycle expected trace built from each store, and
// hand-computed literal checks of memory contents and latency.
module tb_store_processing_unit;

   localparam int unsigned AW   = 32;
   localparam int unsigned NCYC = 4096;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        store_req = 1'b0;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic        busy, done, error, mem_read, mem_write, mem_busywait;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   store_processing_unit #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .resetn(resetn), .store_req(store_req), .func3(func3),
      .address(address), .write_data(write_data), .busy(busy), .done(done),
      .error(error), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_busywait(mem_busywait)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model
   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   int rd_waits = 0, wr_waits = 0, rd_cnt = 0, wr_cnt = 0;
   int reads_seen = 0, writes_seen = 0;

   assign mem_busywait = (mem_read && rd_cnt < rd_waits) || (mem_write && wr_cnt < wr_waits);
   assign mem_rdata    = mem_read ? mem[mem_addr[11:2]] : 32'hA5A5_A5A5;

   always @(posedge clk) begin
      if (mem_read) begin
         if (mem_busywait) rd_cnt <= rd_cnt + 1;
         else begin rd_cnt <= 0; reads_seen <= reads_seen + 1; end
      end else rd_cnt <= 0;
      if (mem_write) begin
         if (mem_busywait) wr_cnt <= wr_cnt + 1;
         else begin
            wr_cnt <= 0;
            writes_seen <= writes_seen + 1;
            mem[mem_addr[11:2]] = mem_wdata;
         end
      end else wr_cnt <= 0;
   end

   // Expected per-cycle trace
   bit          exp_rd [0:NCYC-1];
   bit          exp_wr [0:NCYC-1];
   bit          exp_busy [0:NCYC-1];
   bit          exp_done [0:NCYC-1];
   bit          exp_err [0:NCYC-1];
   logic [31:0] exp_ma [0:NCYC-1];
   logic [31:0] exp_wd [0:NCYC-1];

   int n_chk = 0, n_fail = 0;
   int n_done = 0, n_err = 0, last_done = -1;
   int free_cyc = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < NCYC; i++) begin
         exp_rd[i] = 0; exp_wr[i] = 0; exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
         exp_ma[i] = '0; exp_wd[i] = '0;
      end
   endtask

   // Compare DUT outputs against the expected trace every cycle
   always @(negedge clk) begin
      if (chk_en && cyc < NCYC) begin
         check("mem_read",  32'(mem_read),  32'(exp_rd[cyc]));
         check("mem_write", 32'(mem_write), 32'(exp_wr[cyc]));
         check("busy",      32'(busy),      32'(exp_busy[cyc]));
         check("done",      32'(done),      32'(exp_done[cyc]));
         check("error",     32'(error),     32'(exp_err[cyc]));
         check("addr_align", 32'(mem_addr[1:0]), 32'd0);
         if (exp_rd[cyc] || exp_wr[cyc]) check("mem_addr", mem_addr, exp_ma[cyc]);
         if (exp_wr[cyc]) check("mem_wdata", mem_wdata, exp_wd[cyc]);
      end
      if (done) begin n_done++; last_done = cyc; end
      if (error) n_err++;
   end

   // Issue one store; entered and left at 1 time unit after a rising edge
   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int rw, input int ww, output int c0);
      int t, idx, sh;
      bit legal;
      logic [31:0] w, merged;
      while (cyc < free_cyc) begin @(posedge clk); #1; end
      c0 = cyc;
      legal = (f3 == 3'b000) || (f3 == 3'b001 && a[0] == 1'b0) || (f3 == 3'b010 && a[1:0] == 2'b00);
      rd_waits = rw; wr_waits = ww;
      store_req = 1'b1; func3 = f3; address = a; write_data = d;
      exp_busy[c0] = legal;
      if (!legal) begin
         exp_err[c0+1] = 1;
         @(posedge clk); #1;
         store_req = 1'b0;
         free_cyc = c0 + 1;
         return;
      end
      idx = int'(a[11:2]);
      w = ref_mem[idx];
      case (f3)
         3'b010: merged = d;
         3'b001: begin
            sh = a[1] ? 16 : 0;
            merged = (w & ~(32'h0000_FFFF << sh)) | ((d & 32'h0000_FFFF) << sh);
         end
         default: begin
            sh = 8 * int'(a[1:0]);
            merged = (w & ~(32'h0000_00FF << sh)) | ((d & 32'h0000_00FF) << sh);
         end
      endcase
      ref_mem[idx] = merged;
      t = c0 + 1;
      if (f3 != 3'b010) begin
         for (int i = 0; i <= rw; i++) begin
            exp_rd[t] = 1; exp_busy[t] = 1; exp_ma[t] = {a[31:2], 2'b00}; t++;
         end
      end
      for (int i = 0; i <= ww; i++) begin
         exp_wr[t] = 1; exp_busy[t] = (i < ww); exp_ma[t] = {a[31:2], 2'b00}; exp_wd[t] = merged; t++;
      end
      exp_done[t] = 1;
      free_cyc = t;
      @(posedge clk); #1;
      func3 = 3'b011; address = ~a; write_data = ~d;
      while (cyc < t) begin @(posedge clk); #1; end
      store_req = 1'b0;
   endtask

   task automatic preset(input int idx, input logic [31:0] v);
      mem[idx] = v; ref_mem[idx] = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, c1, w0, r0, e0, d0, got;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = 32'(i) * 32'h9E37_79B1;
         ref_mem[i] = mem[i];
      end
      clear_exp();
      #1 resetn = 1'b0;
      #2;
      check("rst_mem_read",  32'(mem_read),  0);
      check("rst_mem_write", 32'(mem_write), 0);
      check("rst_busy",      32'(busy),      0);
      check("rst_done",      32'(done),      0);
      check("rst_error",     32'(error),     0);
      check("rst_mem_addr",  mem_addr,       0);
      check("rst_mem_wdata", mem_wdata,      0);
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      free_cyc = cyc; chk_en = 1'b1;

      // SW, no waits
      w0 = writes_seen; r0 = reads_seen;
      do_store(3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, c0);
      @(negedge clk); #1;
      check("sw_latency", 32'(last_done - c0), 2);
      check("sw_mem", mem[32'h100 >> 2], 32'hDEAD_BEEF);
      check("sw_no_read", 32'(reads_seen - r0), 0);
      check("sw_one_write", 32'(writes_seen - w0), 1);
      @(posedge clk); #1;

      // SB lane 3, no waits
      preset(32'h200 >> 2, 32'h1122_3344);
      r0 = reads_seen;
      do_store(3'b000, 32'h203, 32'h0000_00AB, 0, 0, c0);
      @(negedge clk); #1;
      check("sb_latency", 32'(last_done - c0), 3);
      check("sb_mem", mem[32'h200 >> 2], 32'hAB22_3344);
      check("sb_one_read", 32'(reads_seen - r0), 1);
      @(posedge clk); #1;

      // SH upper half, two wait cycles in each phase
      preset(32'h200 >> 2, 32'h1122_3344);
      do_store(3'b001, 32'h202, 32'hFFFF_5566, 2, 2, c0);
      @(negedge clk); #1;
      check("sh_latency", 32'(last_done - c0), 7);
      check("sh_mem", mem[32'h200 >> 2], 32'h5566_3344);
      @(posedge clk); #1;

      // Illegal requests
      e0 = n_err; w0 = writes_seen; r0 = reads_seen;
      do_store(3'b001, 32'h201, 32'h1234_5678, 0, 0, c0);
      do_store(3'b010, 32'h102, 32'h1234_5678, 0, 0, c0);
      do_store(3'b011, 32'h100, 32'h1234_5678, 0, 0, c0);
      @(negedge clk); #1;
      check("illegal_errors", 32'(n_err - e0), 3);
      check("illegal_no_write", 32'(writes_seen - w0), 0);
      check("illegal_no_read", 32'(reads_seen - r0), 0);
      check("illegal_mem_intact", mem[32'h100 >> 2], 32'hDEAD_BEEF);
      @(posedge clk); #1;

      // Reset while an SB sits in its read phase
      chk_en = 1'b0;
      w0 = writes_seen;
      rd_waits = 6; wr_waits = 0;
      store_req = 1'b1; func3 = 3'b000; address = 32'h305; write_data = 32'h77;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         @(negedge clk);
         if (mem_read) got = 1;
      end
      check("rstmid_reached_read", 32'(got), 1);
      @(posedge clk); #2;
      resetn = 1'b0; store_req = 1'b0;
      #1;
      check("rstmid_mem_read",  32'(mem_read),  0);
      check("rstmid_mem_write", 32'(mem_write), 0);
      check("rstmid_busy",      32'(busy),      0);
      check("rstmid_done",      32'(done),      0);
      check("rstmid_error",     32'(error),     0);
      check("rstmid_mem_addr",  mem_addr,       0);
      check("rstmid_mem_wdata", mem_wdata,      0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      check("rstmid_no_write", 32'(writes_seen - w0), 0);
      check("rstmid_mem_intact", mem[32'h304 >> 2], ref_mem[32'h304 >> 2]);
      clear_exp();
      free_cyc = cyc; chk_en = 1'b1;

      do_store(3'b010, 32'h104, 32'hCAFE_F00D, 0, 0, c0);
      @(negedge clk); #1;
      check("post_rst_sw_latency", 32'(last_done - c0), 2);
      check("post_rst_sw_mem", mem[32'h104 >> 2], 32'hCAFE_F00D);
      @(posedge clk); #1;

      // Back-to-back SW then SB to the same word
      d0 = n_done;
      do_store(3'b010, 32'h300, 32'h1234_5678, 0, 0, c0);
      do_store(3'b000, 32'h300, 32'h0000_009A, 0, 0, c1);
      @(negedge clk); #1;
      check("b2b_accept_gap", 32'(c1 - c0), 2);
      check("b2b_done_count", 32'(n_done - d0), 2);
      check("b2b_sb_latency", 32'(last_done - c1), 3);
      check("b2b_mem", mem[32'h300 >> 2], 32'h1234_569A);
      @(posedge clk); #1;

      // Mixed stream: every byte lane, both halves, waits, one illegal
      do_store(3'b000, 32'h310, 32'h0000_0011, 1, 0, c0);
      do_store(3'b000, 32'h311, 32'hFFFF_FF22, 0, 1, c0);
      do_store(3'b000, 32'h312, 32'h0000_0033, 0, 0, c0);
      do_store(3'b000, 32'h313, 32'h0000_0044, 3, 0, c0);
      do_store(3'b001, 32'h312, 32'h0000_BEEF, 1, 1, c0);
      do_store(3'b001, 32'h315, 32'h0000_1111, 0, 0, c0);
      do_store(3'b001, 32'h310, 32'h1234_CAFE, 0, 2, c0);
      do_store(3'b010, 32'h314, 32'h0BAD_F00D, 0, 3, c0);
      do_store(3'b000, 32'h317, 32'h0000_FF5A, 2, 2, c0);
      @(negedge clk); #1;
      check("stream_word_310", mem[32'h310 >> 2], 32'hBEEF_CAFE);
      check("stream_word_314", mem[32'h314 >> 2], 32'h5AAD_F00D);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 1024; i++)
         if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
      check("final_mem_200", mem[32'h200 >> 2], 32'h5566_3344);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
